// File: rtl/calyx_arith_pkg.sv
// Shared types and helpers for the sequential arithmetic primitives.
// Imported by the multiplier top and its unsigned core.
package calyx_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    // Bits needed for an iteration counter that must hold the value 'width'.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/std_mult_seq_core.sv
// Unsigned radix-2 shift-and-add core: one multiplier bit per cycle, go/done FSM.
// 'product' is valid only in the cycle 'done' is high; 'start' marks an accepted request.
module std_mult_seq_core
    import calyx_arith_pkg::*;
#(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic [2*width-1:0] product,
    output logic               done,
    output logic               start
);

    localparam int CW = count_width(width);

    mult_state_t        r_state;
    mult_state_t        w_state_next;
    logic [width-1:0]   r_acc;
    logic [width-1:0]   r_mplier;
    logic [width-1:0]   r_mcand;
    logic [CW-1:0]      r_count;
    logic [width:0]     w_sum;
    logic [2*width-1:0] w_shifted;
    logic               w_zero;

    assign w_zero    = (a == '0) || (b == '0);
    // One bit wider than acc so the carry of acc + mcand is shifted in, not lost.
    assign w_sum     = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_shifted = {w_sum, r_mplier[width-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_state_next = r_state;
        product      = '0;
        done         = 1'b0;
        start        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (go) begin
                    start = 1'b1;
                    if (w_zero) begin
                        w_state_next = DONE;
                        done         = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (!go) begin
                    w_state_next = IDLE;
                end else if (r_count == CW'(1)) begin
                    w_state_next = DONE;
                    done         = 1'b1;
                    product      = w_shifted;
                end
            end
            DONE: begin
                if (!go) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= CW'(width);
        end else if (r_state == RUN && go) begin
            {r_acc, r_mplier} <= w_shifted;
            r_count           <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/std_mult_seq.sv
// Sequential multiplier top: sign-magnitude wrapper around the unsigned core.
// Registers the full 2*width product and a one-cycle done pulse.
module std_mult_seq
    import calyx_arith_pkg::*;
#(
    parameter int width       = 32,
    parameter int signed_mode = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out,
    output logic [width-1:0] out_hi,
    output logic             done
);

    logic [width-1:0]   w_left_mag;
    logic [width-1:0]   w_right_mag;
    logic               w_neg;
    logic               r_neg;
    logic               w_core_done;
    logic               w_start;
    logic [2*width-1:0] w_mag_product;
    logic [2*width-1:0] w_product;

    // -2^(width-1) negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        w_left_mag  = left;
        w_right_mag = right;
        w_neg       = 1'b0;
        if (signed_mode != 0) begin
            w_left_mag  = left[width-1]  ? -left  : left;
            w_right_mag = right[width-1] ? -right : right;
            w_neg       = left[width-1] ^ right[width-1];
        end
    end

    std_mult_seq_core #(
        .width(width)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .a      (w_left_mag),
        .b      (w_right_mag),
        .product(w_mag_product),
        .done   (w_core_done),
        .start  (w_start)
    );

    // A zero short-circuit finishes before r_neg is loaded; its product is 0 either way.
    assign w_product = r_neg ? -w_mag_product : w_mag_product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg  <= 1'b0;
            out    <= '0;
            out_hi <= '0;
            done   <= 1'b0;
        end else begin
            if (w_start) r_neg <= w_neg;
            done <= w_core_done;
            if (w_core_done) {out_hi, out} <= w_product;
        end
    end

endmodule

// File: tb/tb_std_mult_seq.sv
// Bench for std_mult_seq at width 8: one unsigned and one signed instance,
// queue scoreboard filled at stimulus time and drained when done pulses.
module tb_std_mult_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          go;
    logic [1:0][W-1:0]   left;
    logic [1:0][W-1:0]   right;
    logic [1:0][W-1:0]   out;
    logic [1:0][W-1:0]   out_hi;
    logic [1:0]          done;

    int checks   = 0;
    int failures = 0;

    exp_t           sb [2][$];
    logic [2*W-1:0] last_p [2];

    always #5 clk = ~clk;

    std_mult_seq #(.width(W), .signed_mode(0)) dut_u (
        .clk(clk), .reset(reset), .go(go[0]), .left(left[0]), .right(right[0]),
        .out(out[0]), .out_hi(out_hi[0]), .done(done[0])
    );

    std_mult_seq #(.width(W), .signed_mode(1)) dut_s (
        .clk(clk), .reset(reset), .go(go[1]), .left(left[1]), .right(right[1]),
        .out(out[1]), .out_hi(out_hi[1]), .done(done[1])
    );

    function automatic logic [2*W-1:0] model(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = (m == 1) ? int'($signed(a)) : int'(a);
        ib = (m == 1) ? int'($signed(b)) : int'(b);
        return (2*W)'(ia * ib);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // Start one operation, wait for done, compare latency and product, hold go, release.
    task automatic run_op(input int m, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   n;
        int   exp_lat;
        logic seen;
        e.a = a;
        e.b = b;
        e.p = model(m, a, b);
        sb[m].push_back(e);
        exp_lat = (a == '0 || b == '0) ? 1 : W + 1;
        @(negedge clk);
        go[m]    = 1'b1;
        left[m]  = a;
        right[m] = b;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4*W) begin
            @(posedge clk);
            #1;
            n++;
            seen = done[m];
            if (n == 1) begin
                left[m]  = W'($urandom);
                right[m] = W'($urandom);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout m=%0d a=%h b=%h got=no done in %0d cycles required=done at %0d", m, a, b, n, exp_lat);
            e = sb[m].pop_front();
        end else begin
            if (n !== exp_lat) begin
                failures++;
                $display("FAIL latency m=%0d a=%h b=%h got=%0d required=%0d", m, a, b, n, exp_lat);
            end
            e = sb[m].pop_front();
            checks++;
            if (out[m] !== e.p[W-1:0]) begin
                failures++;
                $display("FAIL out_lo m=%0d a=%h b=%h got=%h required=%h", m, e.a, e.b, out[m], e.p[W-1:0]);
            end
            checks++;
            if (out_hi[m] !== e.p[2*W-1:W]) begin
                failures++;
                $display("FAIL out_hi m=%0d a=%h b=%h got=%h required=%h", m, e.a, e.b, out_hi[m], e.p[2*W-1:W]);
            end
            last_p[m] = e.p;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done[m] !== 1'b0) begin
                failures++;
                $display("FAIL done_held m=%0d cycle=%0d got=%b required=0", m, i, done[m]);
            end
        end
        @(negedge clk);
        go[m] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (out[m] !== '0) begin
                failures++;
                $display("FAIL reset_out m=%0d got=%h required=00", m, out[m]);
            end
            checks++;
            if (out_hi[m] !== '0) begin
                failures++;
                $display("FAIL reset_out_hi m=%0d got=%h required=00", m, out_hi[m]);
            end
            checks++;
            if (done[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_done m=%0d got=%b required=0", m, done[m]);
            end
            last_p[m] = '0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        run_op(0, 8'd13, 8'd11, 3);
        run_op(0, 8'hFF, 8'hFF, 1);
        run_op(0, 8'd1, 8'h80, 0);
    endtask

    task automatic test_signed();
        run_op(1, 8'hFD, 8'd5, 1);
        run_op(1, 8'h80, 8'h80, 1);
        run_op(1, 8'd7, 8'hFF, 1);
        run_op(1, 8'h7F, 8'h80, 0);
    endtask

    task automatic test_zero();
        run_op(0, 8'd0, 8'd200, 1);
        run_op(0, 8'd200, 8'd0, 1);
        run_op(1, 8'd0, 8'd200, 0);
        run_op(1, 8'd200, 8'd0, 0);
    endtask

    task automatic test_abort();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        go[0]    = 1'b1;
        left[0]  = 8'd13;
        right[0] = 8'd11;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | done[0];
        end
        @(negedge clk);
        go[0] = 1'b0;
        repeat (3*W) begin
            @(posedge clk);
            #1;
            seen = seen | done[0];
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_done got=done seen required=no done");
        end
        checks++;
        if ({out_hi[0], out[0]} !== last_p[0]) begin
            failures++;
            $display("FAIL abort_hold got=%h required=%h", {out_hi[0], out[0]}, last_p[0]);
        end
        run_op(0, 8'd2, 8'd3, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        go[0]    = 1'b1;
        left[0]  = 8'd13;
        right[0] = 8'd11;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({out_hi[m], out[m]} !== '0) begin
                failures++;
                $display("FAIL midreset_out m=%0d got=%h required=0000", m, {out_hi[m], out[m]});
            end
            checks++;
            if (done[m] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_done m=%0d got=%b required=0", m, done[m]);
            end
            last_p[m] = '0;
        end
        go[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 8'd5, 8'd5, 0);
    endtask

    task automatic back_to_back(input int m, input int nops);
        for (int i = 0; i < nops; i++) run_op(m, pick(), pick(), 0);
    endtask

    task automatic test_back_to_back();
        fork
            back_to_back(0, 2500);
            back_to_back(1, 2500);
        join
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (sb[m].size() != 0) begin
                failures++;
                $display("FAIL scoreboard_left m=%0d got=%0d entries required=0", m, sb[m].size());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        go    = '0;
        left  = '0;
        right = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
